// File: rtl/pe_rf_banked.sv
// Banked PE register file: one private bank and write port per lane, plus one
// registered read port per lane that can address any bank. Per-register valid bits make unwritten registers read as zero.
module pe_rf_banked #(
  parameter int NLANES = 4,
  parameter int NREGS  = 8,
  parameter int DATA_W = 32,
  parameter int BYPASS = 0,
  localparam int REG_W  = $clog2(NREGS),
  localparam int BANK_W = $clog2(NLANES),
  localparam int ADDR_W = BANK_W + REG_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NLANES-1:0]              rf_we,
  input  logic [NLANES-1:0][REG_W-1:0]   rd,
  input  logic [NLANES-1:0][DATA_W-1:0]  rd_v,
  input  logic [NLANES-1:0]              re,
  input  logic [NLANES-1:0][ADDR_W-1:0]  rs,
  input  logic                           clr,
  output logic [NLANES-1:0][DATA_W-1:0]  rs_v,
  output logic [NLANES-1:0]              rs_vld
);

  logic [DATA_W-1:0] r_mem   [NLANES][NREGS];
  logic [NREGS-1:0]  r_valid [NLANES];

  // Handshake: there is none; rf_we/re/clr are single-cycle qualifiers sampled
  // on every rising edge, and read results appear one edge after re.

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    // Data array is intentionally not reset; validity lives in r_valid.
    always_ff @(posedge clk) begin
      if (rst_n && rf_we[l]) begin
        r_mem[l][rd[l]] <= rd_v[l];
      end
    end

    // A same-cycle write re-validates its register after a bulk clear.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid[l] <= '0;
      end else begin
        if (clr) begin
          r_valid[l] <= '0;
        end
        if (rf_we[l]) begin
          r_valid[l][rd[l]] <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NLANES; p++) begin : g_port
    logic [BANK_W-1:0] w_bank;
    logic [REG_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_clr_fwd;
    logic              w_vld;
    logic [DATA_W-1:0] w_data;

    assign w_bank = rs[p][ADDR_W-1:REG_W];
    assign w_idx  = rs[p][REG_W-1:0];

    always_comb begin
      w_hit     = 1'b0;
      w_clr_fwd = 1'b0;
      if (BYPASS != 0) begin
        w_hit     = rf_we[w_bank] && (rd[w_bank] == w_idx);
        w_clr_fwd = clr;
      end
      w_vld  = w_hit || (!w_clr_fwd && r_valid[w_bank][w_idx]);
      w_data = '0;
      if (w_hit) begin
        w_data = rd_v[w_bank];
      end else if (w_vld) begin
        w_data = r_mem[w_bank][w_idx];
      end
    end

    // Read register holds its value while re is low.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rs_v[p]   <= '0;
        rs_vld[p] <= 1'b0;
      end else if (re[p]) begin
        rs_v[p]   <= w_data;
        rs_vld[p] <= w_vld;
      end
    end
  end

endmodule

// File: tb/tb_pe_rf_banked.sv
// Directed bench for pe_rf_banked: the same stimulus drives a BYPASS=0 and a
// BYPASS=1 instance, and each port is checked against hand-computed values.
module tb_pe_rf_banked;
  localparam int NL = 4;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NL-1:0]         rf_we;
  logic [NL-1:0][RW-1:0] rd;
  logic [NL-1:0][DW-1:0] rd_v;
  logic [NL-1:0]         re;
  logic [NL-1:0][AW-1:0] rs;
  logic                  clr;
  logic [NL-1:0][DW-1:0] rs_v0, rs_v1;
  logic [NL-1:0]         rs_vld0, rs_vld1;

  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  pe_rf_banked #(.NLANES(NL), .NREGS(NR), .DATA_W(DW), .BYPASS(0)) u_dut_b0 (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .rd(rd), .rd_v(rd_v), .re(re),
    .rs(rs), .clr(clr), .rs_v(rs_v0), .rs_vld(rs_vld0)
  );

  pe_rf_banked #(.NLANES(NL), .NREGS(NR), .DATA_W(DW), .BYPASS(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .rd(rd), .rd_v(rd_v), .re(re),
    .rs(rs), .clr(clr), .rs_v(rs_v1), .rs_vld(rs_vld1)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic [1:0] p,
                            input logic [DW-1:0] d0, input logic v0,
                            input logic [DW-1:0] d1, input logic v1);
    check($sformatf("%s p%0d bypass0 data", tag, p), rs_v0[p], d0);
    check($sformatf("%s p%0d bypass0 vld", tag, p), 32'(rs_vld0[p]), 32'(v0));
    check($sformatf("%s p%0d bypass1 data", tag, p), rs_v1[p], d1);
    check($sformatf("%s p%0d bypass1 vld", tag, p), 32'(rs_vld1[p]), 32'(v1));
  endtask

  task automatic idle();
    rf_we = '0;
    rd    = '0;
    rd_v  = '0;
    re    = '0;
    rs    = '0;
    clr   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr(input int b, input int k);
    return {b[1:0], k[2:0]};
  endfunction

  function automatic logic [DW-1:0] fv(input int b, input int k);
    return 32'hC0DE_0000 | 32'(b * 16 + k);
  endfunction

  initial begin
    logic [DW:0] e;

    // Reset with writes and reads active: writes must be ignored.
    idle();
    rst_n = 1'b0;
    re    = '1;
    rf_we = '1;
    for (int i = 0; i < NL; i++) begin
      rs[i]   = addr(i, 0);
      rd_v[i] = 32'hFFFF_0000 + 32'(i);
    end
    step();
    step();
    for (int p = 0; p < NL; p++) check_port("reset", 2'(p), '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    rf_we = '0;
    step();
    for (int p = 0; p < NL; p++) check_port("post_reset_read", 2'(p), '0, 1'b0, '0, 1'b0);

    // Cross-bank write then read.
    idle();
    rf_we[2] = 1'b1; rd[2] = 3'd5; rd_v[2] = 32'hDEAD_BEEF;
    re[0] = 1'b1; rs[0] = 5'h15;
    step();
    check_port("wr_same_cycle", 2'd0, '0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    idle();
    re[0] = 1'b1; rs[0] = 5'h15;
    re[1] = 1'b1; rs[1] = 5'h15;
    step();
    check_port("wr_next", 2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_port("wr_next", 2'd1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_port("wr_next_idle", 2'd2, '0, 1'b0, '0, 1'b0);

    // Bypass: lane1 write forwards; lane0 write to the same index must not.
    idle();
    rf_we[1] = 1'b1; rd[1] = 3'd3; rd_v[1] = 32'h1234_5678;
    rf_we[0] = 1'b1; rd[0] = 3'd3; rd_v[0] = 32'hBAD0_BAD0;
    re[0] = 1'b1; rs[0] = 5'h0B;
    re[3] = 1'b1; rs[3] = 5'h0B;
    step();
    check_port("bypass", 2'd0, '0, 1'b0, 32'h1234_5678, 1'b1);
    check_port("bypass", 2'd3, '0, 1'b0, 32'h1234_5678, 1'b1);
    check_port("bypass_hold", 2'd1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Fill every register, then clear with a concurrent lane0 write.
    for (int k = 0; k < NR; k++) begin
      idle();
      rf_we = '1;
      for (int b = 0; b < NL; b++) begin
        rd[b]   = 3'(k);
        rd_v[b] = fv(b, k);
      end
      step();
    end
    idle();
    clr = 1'b1;
    rf_we[0] = 1'b1; rd[0] = 3'd0; rd_v[0] = 32'hA5A5_A5A5;
    re = '1;
    rs[0] = addr(0, 0);
    rs[1] = addr(1, 1);
    rs[2] = addr(3, 7);
    rs[3] = addr(2, 2);
    step();
    check_port("clr_cycle", 2'd0, fv(0, 0), 1'b1, 32'hA5A5_A5A5, 1'b1);
    check_port("clr_cycle", 2'd1, fv(1, 1), 1'b1, '0, 1'b0);
    check_port("clr_cycle", 2'd2, fv(3, 7), 1'b1, '0, 1'b0);
    check_port("clr_cycle", 2'd3, fv(2, 2), 1'b1, '0, 1'b0);
    for (int k = 0; k < NR; k++) begin
      idle();
      re = '1;
      for (int p = 0; p < NL; p++) begin
        rs[p] = addr(p, k);
        exp_q.push_back((p == 0 && k == 0) ? {1'b1, 32'hA5A5_A5A5} : {1'b0, 32'h0});
      end
      step();
      for (int p = 0; p < NL; p++) begin
        e = exp_q.pop_front();
        check_port($sformatf("after_clr k%0d", k), 2'(p), e[DW-1:0], e[DW], e[DW-1:0], e[DW]);
      end
    end

    // Read hold while re is low.
    idle();
    rf_we[3] = 1'b1; rd[3] = 3'd7; rd_v[3] = 32'h77;
    step();
    idle();
    re[2] = 1'b1; rs[2] = 5'h1F;
    step();
    check_port("hold_first", 2'd2, 32'h77, 1'b1, 32'h77, 1'b1);
    idle();
    rf_we[3] = 1'b1; rd[3] = 3'd7; rd_v[3] = 32'h88; rs[2] = 5'h1F;
    step();
    check_port("hold_during_write", 2'd2, 32'h77, 1'b1, 32'h77, 1'b1);
    idle();
    step();
    check_port("hold_idle", 2'd2, 32'h77, 1'b1, 32'h77, 1'b1);
    idle();
    re[2] = 1'b1; rs[2] = 5'h1F;
    step();
    check_port("hold_release", 2'd2, 32'h88, 1'b1, 32'h88, 1'b1);

    // Clear alone: bypass0 sees pre-clear state, bypass1 sees cleared.
    idle();
    clr = 1'b1; re[0] = 1'b1; rs[0] = 5'h1F;
    step();
    check_port("clr_only", 2'd0, 32'h88, 1'b1, '0, 1'b0);
    idle();
    re[0] = 1'b1; rs[0] = 5'h1F;
    step();
    check_port("clr_only_next", 2'd0, '0, 1'b0, '0, 1'b0);

    // Reset mid-stream.
    idle();
    rf_we[0] = 1'b1; rd[0] = 3'd1; rd_v[0] = 32'h55;
    step();
    idle();
    rst_n = 1'b0;
    re = '1;
    for (int p = 0; p < NL; p++) rs[p] = addr(0, 1);
    rf_we[1] = 1'b1; rd[1] = 3'd2; rd_v[1] = 32'h66;
    step();
    for (int p = 0; p < NL; p++) check_port("mid_reset", 2'(p), '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    idle();
    re = '1;
    rs[0] = addr(0, 1);
    rs[1] = addr(1, 2);
    rs[2] = addr(0, 0);
    rs[3] = addr(3, 7);
    step();
    for (int p = 0; p < NL; p++) check_port("after_mid_reset", 2'(p), '0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_rf_banked.md
Name: pe_rf_banked

Overview:
Parametrised successor to the PE lane register file. Each of NLANES lanes owns a private bank of NREGS registers and has one write port into that bank. Every lane also has one registered read port that can address any bank. New features:
- per-register valid scoreboard, so unwritten or cleared registers read as zero
- bulk clear
- read-enable hold
- optional same-cycle write-to-read bypass

Parameters:
NLANES, 4, number of lanes, banks, write ports and read ports (power of 2, >=2)
NREGS, 8, registers per bank (power of 2, >=2)
DATA_W, 32, register width in bits
BYPASS, 0, 1 = a read sees a same-cycle write or clear to its register; 0 = a read sees start-of-cycle state
Derived: REG_W = $clog2(NREGS); BANK_W = $clog2(NLANES); ADDR_W = BANK_W + REG_W

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
rf_we  input  [NLANES]  per-lane write enable
rd  input  [NLANES] x REG_W  bank-local write index for each lane
rd_v  input  [NLANES] x DATA_W  write data
re  input  [NLANES]  per-port read enable
rs  input  [NLANES] x ADDR_W  read address; bits [ADDR_W-1:REG_W] = bank, [REG_W-1:0] = index
clr  input  1  single-cycle pulse; invalidates every register in every bank
rs_v  output  [NLANES] x DATA_W  registered read data
rs_vld  output  [NLANES]  registered: the addressed register held valid data

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all valid bits cleared; rs_v = 0; rs_vld = 0
  - data array is not reset
  - writes, reads and clr in the reset cycle are ignored
- Reset mid-stream: takes effect at that edge regardless of other inputs; the next cycle behaves as post-reset.
- Write: rf_we[i]=1 at an edge stores rd_v[i] to bank i, index rd[i], and sets that valid bit.
  - Lane i can write only bank i, so there are no write conflicts.
- Read latency is 1 cycle. With re[i]=1, at the edge:
  - rs_v[i] gets bank rs[i][hi], index rs[i][lo], or 0 if that register is invalid
  - rs_vld[i] gets the valid bit
- Read hold: with re[i]=0, rs_v[i] and rs_vld[i] keep their previous values.
- Any read port may address any bank; multiple ports may read the same register in the same cycle.
- BYPASS=0: a read samples the array and valid bits as they stood at the start of the cycle. A same-cycle write is visible from the next read onward.
- BYPASS=1: a read whose address matches a same-cycle write (lane = bank field, rd = index field) returns that rd_v and vld=1. This is a combinational forward into the read register.
- clr=1 at an edge: all valid bits cleared, data untouched.
  - A same-cycle write still sets its own valid bit (the write wins over clr).
  - BYPASS=1: reads in the clr cycle return 0 / vld=0 unless they hit a same-cycle write, which forwards.
  - BYPASS=0: reads in the clr cycle return pre-clear state.
- Invalid register read: rs_v = 0 exactly, never stale array contents.
- Address decode: all address bits are used; no out-of-range encodings exist, given the power-of-2 parameters.
- Implementation:
  - data as flops or a latch-free array
  - valid bits as NLANES*NREGS flops
  - no combinational path from inputs to outputs

Test Plan:
- Reset then read, defaults: rst_n low 2 cycles, re=all 1, rs[i]=i*8 -> rs_v=0, rs_vld=0 on all ports.
- Write/read across banks, BYPASS=0: cycle0 lane2 writes idx5 = 0xDEADBEEF; cycle1 port0 reads addr 0x15 -> cycle2 rs_v[0]=0xDEADBEEF, rs_vld[0]=1. A read of 0x15 issued in cycle0 returns 0 / vld 0.
- Bypass, BYPASS=1: lane1 writes idx3 = 0x12345678 while ports 0 and 3 read addr 0x0B in the same cycle -> next cycle both return 0x12345678, vld=1.
- Clear with concurrent write: fill all 32 registers; pulse clr while lane0 writes idx0 = 0xA5A5A5A5 -> afterwards addr 0x00 reads 0xA5A5A5A5/vld 1 and every other address reads 0/vld 0.
- Read hold: port2 reads 0x1F = 0x77 (rs_v=0x77); drop re[2] and overwrite 0x1F with 0x88 -> rs_v[2] stays 0x77 until re[2] is reasserted, then 0x88.
- Parameter sweep: NLANES=8, NREGS=16, DATA_W=16, random writes/reads/clr against a reference model for 10k cycles, including rst_n asserted mid-run -> zero mismatches; outputs 0 the cycle after reset.
